// File: rtl/grad_window_gather.sv
// 3x3 cross-window gatherer: streams raster pixels through two line buffers and
// emits {down, up, right, left} around each interior centre with a valid/ready hold.
module grad_window_gather #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_data,
  input  logic        frame_start,
  output logic        pixel_ready,
  output logic        window_valid,
  input  logic        window_ready,
  output logic [31:0] window_data,
  output logic [9:0]  center_x,
  output logic [9:0]  center_y,
  output logic        frame_done
);

  localparam int         AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_HEIGHT - 1);

  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [9:0]    cur_col, cur_row;
  logic [AW-1:0] lb_idx;
  logic          accept, emit, last_px;

  logic [7:0]    lb1_q [IMG_WIDTH];
  logic [7:0]    lb2_q [IMG_WIDTH];
  logic [7:0]    lb1_rd, lb2_rd;

  // Neighbours of the current column: row-1 at c-1/c-2, row-2 at c-1, current row at c-1.
  logic [7:0]    r1c1_q, r1c2_q, r2c1_q, cur_c1_q;

  logic          win_valid_q, win_valid_d;
  logic [31:0]   win_data_q, win_data_d;
  logic [9:0]    cx_q, cx_d, cy_q, cy_d;
  logic          fd_q, fd_d;

  always_comb begin
    pixel_ready = !win_valid_q || window_ready;
    accept      = pixel_valid && pixel_ready;
    cur_col     = frame_start ? '0 : col_q;
    cur_row     = frame_start ? '0 : row_q;
    lb_idx      = cur_col[AW-1:0];
    lb1_rd      = lb1_q[lb_idx];
    lb2_rd      = lb2_q[lb_idx];
    emit        = accept && (cur_col >= 10'd2) && (cur_row >= 10'd2);
    last_px     = (cur_col == LAST_COL) && (cur_row == LAST_ROW);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 10'd1;
      end else begin
        col_d = cur_col + 10'd1;
        row_d = cur_row;
      end
    end
  end

  // A window load on the handshake edge takes priority over clearing valid.
  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_data_d  = {cur_c1_q, r2c1_q, lb1_rd, r1c2_q};
      cx_d        = cur_col - 10'd1;
      cy_d        = cur_row - 10'd1;
    end else if (window_ready) begin
      win_valid_d = 1'b0;
    end
    fd_d = accept && last_px;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      fd_q        <= fd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      lb2_q[lb_idx] <= lb1_rd;
      lb1_q[lb_idx] <= pixel_data;
      r1c2_q        <= r1c1_q;
      r1c1_q        <= lb1_rd;
      r2c1_q        <= lb2_rd;
      cur_c1_q      <= pixel_data;
    end
  end

  assign window_valid = win_valid_q;
  assign window_data  = win_data_q;
  assign center_x     = cx_q;
  assign center_y     = cy_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_grad_window_gather.sv
// Randomised and directed bench for grad_window_gather against a frame-image reference model.
module tb_grad_window_gather;

  localparam int W = 4;
  localparam int H = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [7:0]  pixel_data;
  logic        frame_start;
  logic        pixel_ready;
  logic        window_valid;
  logic        window_ready;
  logic [31:0] window_data;
  logic [9:0]  center_x;
  logic [9:0]  center_y;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
  } win_t;

  win_t       exp_q[$];
  win_t       obs_q[$];
  win_t       ref_q[$];
  logic [7:0] img [H][W];
  int         mx = 0;
  int         my = 0;
  logic       fd_next = 1'b0;
  int         fd_count = 0;
  logic       valid_seen = 1'b0;
  logic       rdy_random = 1'b0;

  always #5 clock = ~clock;

  grad_window_gather #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .frame_start  (frame_start),
    .pixel_ready  (pixel_ready),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .window_data  (window_data),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a picture of the current frame plus a queue of owed windows.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      mx = 0;
      my = 0;
      fd_next = 1'b0;
    end else begin
      check("pixel_ready", {31'b0, pixel_ready}, {31'b0, (!window_valid || window_ready)});
      check("frame_done", {31'b0, frame_done}, {31'b0, fd_next});
      if (frame_done) fd_count++;
      if (window_valid) valid_seen = 1'b1;
      check("window_valid", {31'b0, window_valid}, {31'b0, (exp_q.size() != 0)});
      if (window_valid && exp_q.size() != 0) begin
        check("window_data", window_data, exp_q[0].d);
        check("center_x", {22'b0, center_x}, {22'b0, exp_q[0].x});
        check("center_y", {22'b0, center_y}, {22'b0, exp_q[0].y});
      end
      if (window_valid && window_ready) begin
        win_t o;
        o.d = window_data;
        o.x = center_x;
        o.y = center_y;
        obs_q.push_back(o);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      fd_next = 1'b0;
      if (pixel_valid && pixel_ready) begin
        if (frame_start) begin
          mx = 0;
          my = 0;
        end
        img[my][mx] = pixel_data;
        if (mx >= 2 && my >= 2) begin
          win_t e;
          e.d = {img[my][mx-1], img[my-2][mx-1], img[my-1][mx], img[my-1][mx-2]};
          e.x = 10'(mx - 1);
          e.y = 10'(my - 1);
          exp_q.push_back(e);
        end
        fd_next = (mx == W - 1) && (my == H - 1);
        mx++;
        if (mx == W) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (rdy_random) window_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic fs, input int gap);
    logic acc;
    int   waited;
    idle(gap);
    pixel_valid = 1'b1;
    pixel_data  = d;
    frame_start = fs;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 200) begin
      @(negedge clock);
      acc = pixel_ready;
      @(posedge clock);
      #1;
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance, required acceptance within 200 cycles");
    end
    pixel_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  // Pixels k in [first,last] of a frame, value 16*row+col.
  task automatic send_part(input int first, input int last, input int gap, input logic fs_first);
    for (int k = first; k <= last; k++) begin
      int x;
      int y;
      x = k % W;
      y = k / W;
      send_px(8'(16 * y + x), fs_first && (k == first), gap);
    end
  endtask

  task automatic compare_to_ref(input string name);
    check({name, "_count"}, obs_q.size(), ref_q.size());
    if (obs_q.size() == ref_q.size()) begin
      for (int i = 0; i < ref_q.size(); i++) begin
        check({name, "_data"}, obs_q[i].d, ref_q[i].d);
        check({name, "_cx"}, {22'b0, obs_q[i].x}, {22'b0, ref_q[i].x});
        check({name, "_cy"}, {22'b0, obs_q[i].y}, {22'b0, ref_q[i].y});
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    pixel_valid  = 1'b0;
    pixel_data   = '0;
    frame_start  = 1'b0;
    window_ready = 1'b1;
    #1;
    check("rst_window_valid", {31'b0, window_valid}, 32'd0);
    check("rst_window_data", window_data, 32'd0);
    check("rst_center_x", {22'b0, center_x}, 32'd0);
    check("rst_center_y", {22'b0, center_y}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_pixel_ready", {31'b0, pixel_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Full frame, consumer always ready.
    obs_q.delete();
    fd_count = 0;
    send_part(0, 15, 0, 1'b1);
    idle(3);
    check("f1_windows", obs_q.size(), 32'd4);
    check("f1_frame_done_pulses", fd_count, 32'd1);
    if (obs_q.size() == 4) begin
      check("f1_first_data", obs_q[0].d, 32'h21011210);
      check("f1_first_cx", {22'b0, obs_q[0].x}, 32'd1);
      check("f1_first_cy", {22'b0, obs_q[0].y}, 32'd1);
      check("f1_last_data", obs_q[3].d, 32'h32122321);
    end
    ref_q = obs_q;

    // Consumer stalls on the first window, then releases.
    obs_q.delete();
    send_part(0, 10, 0, 1'b1);
    window_ready = 1'b0;
    pixel_valid  = 1'b1;
    pixel_data   = 8'h23;
    repeat (4) begin
      @(negedge clock);
      check("stall_valid", {31'b0, window_valid}, 32'd1);
      check("stall_data", window_data, 32'h21011210);
      check("stall_pixel_ready", {31'b0, pixel_ready}, 32'd0);
      @(posedge clock);
      #1;
    end
    window_ready = 1'b1;
    send_part(11, 15, 0, 1'b0);
    idle(3);
    compare_to_ref("stall");

    // Rows 0-1 only: no window may appear.
    obs_q.delete();
    valid_seen = 1'b0;
    send_part(0, 7, 0, 1'b1);
    idle(2);
    check("rows01_valid_seen", {31'b0, valid_seen}, 32'd0);

    // frame_start on pixel (1,2) restarts the frame there.
    send_part(8, 8, 0, 1'b0);
    obs_q.delete();
    send_part(0, 15, 0, 1'b1);
    idle(3);
    check("fs_windows", obs_q.size(), 32'd4);
    if (obs_q.size() == 4) begin
      check("fs_last_data", obs_q[3].d, 32'h32122321);
      check("fs_last_cx", {22'b0, obs_q[3].x}, 32'd2);
      check("fs_last_cy", {22'b0, obs_q[3].y}, 32'd2);
    end

    // Reset while a window is pending.
    send_part(0, 10, 0, 1'b1);
    window_ready = 1'b0;
    @(negedge clock);
    check("prerst_valid", {31'b0, window_valid}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, window_valid}, 32'd0);
    check("midrst_data", window_data, 32'd0);
    check("midrst_cx", {22'b0, center_x}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    window_ready = 1'b1;
    obs_q.delete();
    fd_count = 0;
    send_part(0, 15, 0, 1'b0);
    idle(3);
    compare_to_ref("after_reset");
    check("after_reset_fd", fd_count, 32'd1);

    // pixel_valid toggling every other cycle.
    obs_q.delete();
    send_part(0, 15, 1, 1'b1);
    idle(3);
    compare_to_ref("toggle");

    // Random data, gaps, backpressure and occasional frame restarts.
    rdy_random = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_px(8'($urandom), (i == 0) || ($urandom_range(0, 39) == 0), $urandom_range(0, 2));
    end
    idle(1);
    rdy_random = 1'b0;
    window_ready = 1'b1;
    idle(5);
    check("random_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
